// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter.
// Double dabble, one magnitude bit per clock.
module seq_bin_to_bcd #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  negative,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t          r_state;
  logic [BIN_W-1:0] r_mag;
  logic [BW-1:0]   r_work;
  logic [CW-1:0]   r_cnt;
  logic            r_sign;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;
  logic [BW-1:0]   r_bcd;
  logic            r_neg_q;
  logic            r_ovf_q;

  logic             w_neg;
  logic [BIN_W-1:0] w_mag;
  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_shift;
  logic             w_out;

  // Sign and magnitude of the incoming operand; -2^(W-1) maps to 2^(W-1).
  always_comb begin
    w_neg = (SIGNED != 0) && bin_in[BIN_W-1];
    w_mag = bin_in;
    if (w_neg) begin
      w_mag = (~bin_in) + {{(BIN_W-1){1'b0}}, 1'b1};
    end
  end

  // Add-3 to every digit >= 5, then shift in the next magnitude bit.
  always_comb begin
    w_adj = r_work;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_work[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
      end
    end
    w_shift = {w_adj[BW-2:0], r_mag[BIN_W-1]};
    w_out   = w_adj[BW-1];
  end

  // Control FSM plus datapath; results only update on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mag   <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_neg_q <= 1'b0;
      r_ovf_q <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mag   <= w_mag;
            r_sign  <= w_neg;
            r_work  <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_work <= w_shift;
          r_mag  <= {r_mag[BIN_W-2:0], 1'b0};
          r_ovf  <= r_ovf | w_out;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bcd   <= w_shift;
            r_neg_q <= r_sign;
            r_ovf_q <= r_ovf | w_out;
          end
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign negative = r_neg_q;
  assign overflow = r_ovf_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Directed and sweep bench for seq_bin_to_bcd.
// Three instances: default, DIGITS=3, SIGNED=1.
module tb_seq_bin_to_bcd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bin_in;

  logic        busy_a, done_a, neg_a, ovf_a;
  logic [15:0] bcd_a;
  logic        busy_b, done_b, neg_b, ovf_b;
  logic [11:0] bcd_b;
  logic        busy_c, done_c, neg_c, ovf_c;
  logic [15:0] bcd_c;

  int total = 0;
  int bad   = 0;
  int lat;

  seq_bin_to_bcd u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a),
    .negative(neg_a), .overflow(ovf_a)
  );

  seq_bin_to_bcd #(.BIN_W(12), .DIGITS(3), .SIGNED(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
    .negative(neg_b), .overflow(ovf_b)
  );

  seq_bin_to_bcd #(.BIN_W(12), .DIGITS(4), .SIGNED(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy_c), .done(done_c), .bcd_out(bcd_c),
    .negative(neg_c), .overflow(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] to_bcd(input int unsigned m,
                                         input int nd);
    logic [63:0] r;
    r = '0;
    for (int d = 0; d < nd; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Pulse start with v, return edges after the start edge until done.
  task automatic run(input logic [11:0] v, output int n);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!done_a && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int          sv;
    int unsigned mg;
    logic [15:0] prev;

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_bcd",  bcd_a,  0);
    chk("rst_neg",  neg_c,  0);
    chk("rst_ovf",  ovf_a,  0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    start  = 1'b1;
    bin_in = 12'd4095;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy_a, 1);
    lat = 0;
    while (!done_a && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("lat_4095",  lat,   12);
    chk("bcd_4095",  bcd_a, 16'h4095);
    chk("ovf_4095",  ovf_a, 0);
    chk("busy_done", busy_a, 0);
    @(posedge clk);
    #1;
    chk("done_pulse", done_a, 0);
    chk("bcd_hold",   bcd_a,  16'h4095);

    run(12'd0, lat);
    chk("bcd_0",  bcd_a, 16'h0000);
    chk("neg_0",  neg_a, 0);
    chk("negs_0", neg_c, 0);
    chk("bcds_0", bcd_c, 16'h0000);

    run(12'd9, lat);
    chk("bcd_9", bcd_a, 16'h0009);

    run(12'd1234, lat);
    chk("d3_ovf_1234", ovf_b, 1);
    chk("d3_bcd_1234", bcd_b, 12'h234);
    chk("d4_ovf_1234", ovf_a, 0);
    chk("d4_bcd_1234", bcd_a, 16'h1234);

    run(12'h800, lat);
    chk("s_neg_800", neg_c, 1);
    chk("s_bcd_800", bcd_c, 16'h2048);
    chk("s_ovf_800", ovf_c, 0);
    run(12'hFFF, lat);
    chk("s_neg_fff", neg_c, 1);
    chk("s_bcd_fff", bcd_c, 16'h0001);
    chk("u_neg_fff", neg_a, 0);

    // 100, then 200 mid-conversion (ignored), then 300 in done cycle.
    prev = bcd_a;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 12'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done_a && lat < 40) begin
      if (lat == 4) begin
        @(negedge clk);
        start  = 1'b1;
        bin_in = 12'd200;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (lat == 6) chk("no_interm", bcd_a, prev);
    end
    chk("lat_100", lat, 12);
    chk("bcd_100", bcd_a, 16'h0100);
    run(12'd300, lat);
    chk("lat_300", lat, 12);
    chk("bcd_300", bcd_a, 16'h0300);

    // Abort 777 during its sixth shift cycle.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 12'd777;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_bcd",  bcd_a,  0);
    chk("abort_negc", neg_c,  0);
    chk("abort_ovfb", ovf_b,  0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (done_a) lat++;
    end
    chk("abort_no_done", lat, 0);
    run(12'd777, lat);
    chk("lat_777", lat, 12);
    chk("bcd_777", bcd_a, 16'h0777);

    // Full input sweep against a decimal model.
    for (int i = 0; i < 4096; i++) begin
      run(12'(i), lat);
      chk("sw_lat",  lat,   12);
      chk("sw_bcd",  bcd_a, to_bcd(i, 4));
      chk("sw_ovf",  ovf_a, 0);
      chk("sw3_bcd", bcd_b, to_bcd(i % 1000, 3));
      chk("sw3_ovf", ovf_b, (i > 999) ? 1 : 0);
      sv = (i >= 2048) ? i - 4096 : i;
      mg = (sv < 0) ? -sv : sv;
      chk("sws_bcd", bcd_c, to_bcd(mg, 4));
      chk("sws_neg", neg_c, (sv < 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
